// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between an interconnect-side master and a memory slave.
// Clock and reset stay outside the bundle as plain ports.
interface ahb_lite_mem_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        HREADY;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, HREADY,
        output hready_resp, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, HREADY,
        input  hready_resp, hresp, hrdata
    );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with programmable wait states,
// byte-lane writes and a two-cycle ERROR response for illegal transfers.
module ahb_lite_mem_slave #(
    parameter int ADDR_WORDS  = 64,
    parameter int WAIT_STATES = 1
) (
    input logic                 HCLK,
    input logic                 HRESET,
    ahb_lite_mem_slave_if.slave bus
);
    localparam int         IDX_W     = $clog2(ADDR_WORDS);
    localparam logic [1:0] WAIT_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t           state, state_nxt;
    logic [1:0]       wait_cnt, wait_cnt_nxt;
    logic             data_pending, data_pending_nxt;
    logic             hready_int;
    logic             accept, addr_err, complete;
    logic [3:0]       byte_en;

    logic             lat_write;
    logic [1:0]       lat_size;
    logic [1:0]       lat_lane;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      mem [ADDR_WORDS];

    // Address-phase decode; bits 31:29 belong to the upstream decoder.
    assign accept   = bus.hsel && bus.HREADY && bus.htrans[1] && hready_int;
    assign addr_err = (bus.hsize > 3'd2)
                   || (bus.hsize == 3'd1 && bus.haddr[0])
                   || (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00)
                   || (bus.haddr[28:2] >= 27'(ADDR_WORDS));

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.hburst, bus.hprot, bus.haddr[31:29]};

    assign hready_int      = (state != S_WAIT) && (state != S_ERR1);
    assign bus.hready_resp = hready_int;
    assign bus.hresp       = (state == S_ERR1 || state == S_ERR2) ? RESP_ERR : RESP_OKAY;

    // A pending OKAY phase finishes in whichever cycle the slave is ready.
    assign complete   = hready_int && data_pending;
    assign bus.hrdata = (complete && !lat_write) ? mem[lat_idx] : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= S_IDLE;
            wait_cnt     <= 2'd0;
            data_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            data_pending <= data_pending_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        data_pending_nxt = data_pending;
        case (state)
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = S_IDLE;
                    wait_cnt_nxt = 2'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: ;
        endcase
        // A ready cycle retires the current phase and opens whatever is accepted now.
        if (hready_int) begin
            data_pending_nxt = 1'b0;
            state_nxt        = S_IDLE;
            if (accept) begin
                if (addr_err) begin
                    state_nxt = S_ERR1;
                end else begin
                    data_pending_nxt = 1'b1;
                    wait_cnt_nxt     = 2'd0;
                    state_nxt        = (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
                end
            end
        end
    end

    // Transfer attributes need no reset: data_pending gates every use of them.
    always_ff @(posedge HCLK) begin
        if (accept && !addr_err) begin
            lat_write <= bus.hwrite;
            lat_size  <= bus.hsize[1:0];
            lat_lane  <= bus.haddr[1:0];
            lat_idx   <= bus.haddr[IDX_W+1:2];
        end
    end

    always_comb begin
        case (lat_size)
            2'd0:    byte_en = 4'b0001 << lat_lane;
            2'd1:    byte_en = lat_lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Reads sample the array in their own completing cycle, after any earlier
    // write has committed, so back-to-back same-word reads need no bypass.
    // NOTE: the array is reset explicitly because its contents must read back as zero after reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < ADDR_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (complete && lat_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[lat_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
- REQ-001 SHALL have parameter ADDR_WORDS, default 64: number of 32-bit memory words, a power of 2 in the range 4..256.
- REQ-002 SHALL have parameter WAIT_STATES, default 1: number of wait cycles inserted per OKAY data phase, range 0..3.
- REQ-003 SHALL have the following ports:
  - HCLK  in  1  clock; all logic on the rising edge.
  - HRESET  in  1  synchronous, active-high reset.
  - hsel  in  1  slave select from the interconnect decoder.
  - haddr  in  32  address.
  - htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - hsize  in  3  transfer size.
  - hburst  in  3  burst type; ignored.
  - hprot  in  4  protection; ignored.
  - hwrite  in  1  1 = write.
  - hwdata  in  32  write data.
  - HREADY  in  1  bus-wide ready.
  - hready_resp  out  1  this slave's ready.
  - hresp  out  2  response: OKAY=00, ERROR=01.
  - hrdata  out  32  read data.

Function
- REQ-004 SHALL accept a transfer only in a cycle where hsel=1, HREADY=1 and htrans[1]=1 (NONSEQ or SEQ). At that edge it SHALL latch haddr, hsize and hwrite.
- REQ-005 SHALL treat IDLE, BUSY, hsel=0 or HREADY=0 as "no transfer". The following data cycle is then zero-wait OKAY: hready_resp=1, hresp=00.
- REQ-006 SHALL flag an accepted transfer as an error if any of these hold:
  - hsize>2;
  - hsize=1 and haddr[0]=1;
  - hsize=2 and haddr[1:0]!=0;
  - the word index haddr[31:2] is >= ADDR_WORDS, counting bits 28 and below only (bits 31:29 are decoded upstream).
- REQ-007 SHALL implement FSM states IDLE, WAIT, ERR1 and ERR2.
- REQ-008 FSM transitions:
  - IDLE -> WAIT on a valid accept when WAIT_STATES>0.
  - IDLE -> IDLE (completes immediately) on a valid accept when WAIT_STATES=0.
  - IDLE -> ERR1 on an error accept.
  - WAIT -> IDLE after WAIT_STATES cycles, counted by a 2-bit counter.
  - ERR1 -> ERR2 -> IDLE.
- REQ-009 hready_resp SHALL be 0 in WAIT and in ERR1, and 1 in all other states.
- REQ-010 hresp SHALL be 01 in ERR1 and ERR2, and 00 in all other states.
- REQ-011 An OKAY data phase SHALL last exactly WAIT_STATES+1 cycles. It completes in the cycle where hready_resp=1.
- REQ-012 A write SHALL commit hwdata into memory at the completing edge, using byte enables derived from the latched hsize and haddr[1:0]:
  - byte: one lane, selected by addr[1:0];
  - halfword: lanes {1,0} or {3,2}, selected by addr[1];
  - word: all four lanes.
- REQ-013 A read SHALL drive hrdata with the full addressed word during the completing cycle. hrdata SHALL be 0 in every other cycle, including during errors.
- REQ-014 Erroring transfers SHALL NOT modify memory.
- REQ-015 During the completing cycle (hready_resp=1), the slave SHALL accept a new address phase, so back-to-back transfers are pipelined.
- REQ-016 During WAIT and ERR1, HREADY is low bus-wide, so no new transfer SHALL be accepted.
- REQ-017 A read whose address phase overlaps a write's completing cycle to the same word SHALL return the newly written data. No stale data is permitted.
- REQ-018 If hsel drops during a data phase, the data phase SHALL still complete normally.

Reset
- REQ-019 While HRESET=1 at a rising edge, the following SHALL hold after that edge:
  - FSM state = IDLE and wait counter = 0;
  - hready_resp = 1, hresp = 00, hrdata = 0;
  - every memory word cleared to 0;
  - latched transfer information discarded.
- REQ-020 A reset asserted mid data phase (WAIT or ERR1) SHALL abandon the transfer with no memory write. The next cycle SHALL be IDLE.
- REQ-021 A transfer accepted in the same cycle as HRESET=1 SHALL be ignored.

Verification
- REQ-022 WAIT_STATES=1: word write 0xDEADBEEF to 0x04, then word read of 0x04 -> each data phase has hready_resp low for 1 cycle, then high with hresp=00; the read returns 0xDEADBEEF.
- REQ-023 Byte write 0xAA to 0x09 over a word 0x00000000 -> a word read of 0x08 returns 0x0000AA00.
- REQ-024 Halfword access at 0x03 -> hready_resp=0/hresp=01, then hready_resp=1/hresp=01; a later read of 0x00 shows memory unchanged.
- REQ-025 Out-of-range word read at 0x100 (ADDR_WORDS=64) -> two-cycle ERROR as in REQ-024; hrdata=0.
- REQ-026 WAIT_STATES=0: back-to-back NONSEQ write 0x12345678 to 0x10 followed immediately by a read of 0x10 -> the read completes the next cycle with 0x12345678.
- REQ-027 HRESET asserted in the WAIT cycle of a write of 0xFFFFFFFF to 0x20 -> the next cycle is IDLE with hready_resp=1; a read of 0x20 returns 0x00000000.
